// File: rtl/seg7_pkg.sv
// ============================================================================
// Module : seg7_pkg
// Brief  : Shared glyph table and constants for the 7-segment scan driver.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package seg7_pkg;

    localparam int MAX_DIGITS = 8;

    localparam logic [6:0] SEG_DARK = 7'h7F;

    // Active-low glyphs {g,f,e,d,c,b,a}, indexed by nibble 0x0..0xF
    localparam logic [6:0] GLYPH [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

endpackage

`default_nettype wire

// File: rtl/seg7_decode.sv
// ============================================================================
// Module : seg7_decode
// Brief  : Combinational hex nibble to active-low segment pattern.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg_n
);

    assign seg_n = GLYPH[nibble];

endmodule

`default_nettype wire

// File: rtl/seg7_scan_driver.sv
// ============================================================================
// Module : seg7_scan_driver
// Brief  : Time-multiplexed hex display driver with frame-synchronous
//          double buffering. Define SEG7_LZ_BLANK_EN for leading-zero blanking.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int DIGITS         = 4,
    parameter int REFRESH_DIV    = 50000,
    parameter int SEG_ACTIVE_LOW = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp_mask,
    input  logic [DIGITS-1:0]     blank_mask,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [DIGITS-1:0]     an,
    output logic                  frame_tick,
    output logic                  pending
);

    localparam int DIV_W = $clog2(REFRESH_DIV);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);
    localparam logic [6:0]       SEG_OFF  = (SEG_ACTIVE_LOW != 0) ? SEG_DARK : ~SEG_DARK;
    localparam logic             DP_OFF   = (SEG_ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

    logic [DIV_W-1:0]    r_div;
    logic [IDX_W-1:0]    r_idx;
    logic [4*DIGITS-1:0] r_act_value, r_sh_value;
    logic [DIGITS-1:0]   r_act_dp, r_sh_dp;
    logic [DIGITS-1:0]   r_act_blank, r_sh_blank;
    logic                r_pending;
    logic                r_fb_d;
    logic                r_frame_tick;
    logic [6:0]          r_seg;
    logic                r_dp;
    logic [DIGITS-1:0]   r_an;

    logic                w_tc, w_fb;
    logic [3:0]          w_nibble;
    logic [6:0]          w_glyph;
    logic [DIGITS-1:0]   w_lz;
    logic                w_dark;
    logic [6:0]          w_seg_lo, w_seg_pol;
    logic                w_dp_lo, w_dp_pol;
    logic [DIGITS-1:0]   w_an;

    assign w_tc = (r_div == DIV_LAST);
    assign w_fb = w_tc && (r_idx == IDX_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_div <= '0;
            r_idx <= '0;
        end else if (w_tc) begin
            r_div <= '0;
            r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
        end else begin
            r_div <= r_div + 1'b1;
        end
    end

    // A load landing on the frame boundary goes straight to the active set
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_act_value <= '0;
            r_act_dp    <= '0;
            r_act_blank <= '0;
            r_sh_value  <= '0;
            r_sh_dp     <= '0;
            r_sh_blank  <= '0;
            r_pending   <= 1'b0;
        end else if (load && w_fb) begin
            r_act_value <= value;
            r_act_dp    <= dp_mask;
            r_act_blank <= blank_mask;
            r_pending   <= 1'b0;
        end else begin
            if (load) begin
                r_sh_value <= value;
                r_sh_dp    <= dp_mask;
                r_sh_blank <= blank_mask;
                r_pending  <= 1'b1;
            end else if (w_fb && r_pending) begin
                r_act_value <= r_sh_value;
                r_act_dp    <= r_sh_dp;
                r_act_blank <= r_sh_blank;
                r_pending   <= 1'b0;
            end
        end
    end

`ifdef SEG7_LZ_BLANK_EN
    logic w_hz;

    always_comb begin
        w_lz = '0;
        w_hz = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            w_lz[i] = w_hz && (r_act_value[4*i +: 4] == 4'h0) && !r_act_dp[i];
            w_hz    = w_lz[i];
        end
    end
`else
    assign w_lz = '0;
`endif

    assign w_nibble = r_act_value[{r_idx, 2'b00} +: 4];

    seg7_decode u_decode (
        .nibble (w_nibble),
        .seg_n  (w_glyph)
    );

    assign w_dark   = r_act_blank[r_idx] | w_lz[r_idx];
    assign w_seg_lo = w_dark ? SEG_DARK : w_glyph;
    assign w_dp_lo  = w_dark | ~r_act_dp[r_idx];
    assign w_an     = w_dark ? '1 : ~(DIGITS'(1) << r_idx);

    if (SEG_ACTIVE_LOW != 0) begin : g_active_low
        assign w_seg_pol = w_seg_lo;
        assign w_dp_pol  = w_dp_lo;
    end else begin : g_active_high
        assign w_seg_pol = ~w_seg_lo;
        assign w_dp_pol  = ~w_dp_lo;
    end

    // frame_tick is delayed twice so it coincides with the registered digit-0 enable
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_seg        <= SEG_OFF;
            r_dp         <= DP_OFF;
            r_an         <= '1;
            r_fb_d       <= 1'b0;
            r_frame_tick <= 1'b0;
        end else begin
            r_seg        <= w_seg_pol;
            r_dp         <= w_dp_pol;
            r_an         <= w_an;
            r_fb_d       <= w_fb;
            r_frame_tick <= r_fb_d;
        end
    end

    assign seg        = r_seg;
    assign dp         = r_dp;
    assign an         = r_an;
    assign frame_tick = r_frame_tick;
    assign pending    = r_pending;

endmodule

`default_nettype wire
